// File: rtl/mcp_pkg.sv
// Shared definitions for the MIPS multicycle control unit: opcodes, FSM states,
// datapath select encodings and the packed control vector.
package mcp_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEX   = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11
    } state_t;

    localparam logic [1:0] PC_SRC_ALU    = 2'd0;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
    localparam logic [1:0] PC_SRC_JUMP   = 2'd2;

    localparam logic [1:0] B_SEL_REG     = 2'd0;
    localparam logic [1:0] B_SEL_FOUR    = 2'd1;
    localparam logic [1:0] B_SEL_IMM     = 2'd2;
    localparam logic [1:0] B_SEL_IMM_SH2 = 2'd3;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

    typedef struct packed {
        logic       pc_we;
        logic [1:0] pc_branch;
        logic       instr_or_data;
        logic       instr_we;
        logic       reg_dst_rtrd;
        logic       mem_to_reg;
        logic       enable_wrf;
        logic       a_alu_input;
        logic [1:0] b_alu_input;
        logic [1:0] alu_alt_ctrl;
        logic       mem_we;
        logic       retire;
    } ctrl_t;

    function automatic logic is_supported(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
    endfunction

endpackage

// File: rtl/mcp_ctrl_outputs.sv
// Moore output decode for the multicycle controller; zero_i only reaches
// pc_we in BRANCH so a taken branch writes the PC in the same cycle.
module mcp_ctrl_outputs
    import mcp_pkg::*;
(
    input  state_t state,
    input  logic   zero_i,
    output ctrl_t  ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.instr_we     = 1'b1;
                ctrl.b_alu_input  = B_SEL_FOUR;
                ctrl.alu_alt_ctrl = ALU_OP_ADD;
                ctrl.pc_branch    = PC_SRC_ALU;
                ctrl.pc_we        = 1'b1;
            end
            S_DECODE: begin
                ctrl.b_alu_input  = B_SEL_IMM_SH2;
                ctrl.alu_alt_ctrl = ALU_OP_ADD;
            end
            S_MEMADR, S_ADDIEX: begin
                ctrl.a_alu_input  = 1'b1;
                ctrl.b_alu_input  = B_SEL_IMM;
                ctrl.alu_alt_ctrl = ALU_OP_ADD;
            end
            S_MEMREAD: ctrl.instr_or_data = 1'b1;
            S_MEMWB: begin
                ctrl.mem_to_reg = 1'b1;
                ctrl.enable_wrf = 1'b1;
                ctrl.retire     = 1'b1;
            end
            S_MEMWRITE: begin
                ctrl.instr_or_data = 1'b1;
                ctrl.mem_we        = 1'b1;
                ctrl.retire        = 1'b1;
            end
            S_EXECUTE: begin
                ctrl.a_alu_input  = 1'b1;
                ctrl.b_alu_input  = B_SEL_REG;
                ctrl.alu_alt_ctrl = ALU_OP_FUNCT;
            end
            S_ALUWB: begin
                ctrl.reg_dst_rtrd = 1'b1;
                ctrl.enable_wrf   = 1'b1;
                ctrl.retire       = 1'b1;
            end
            S_BRANCH: begin
                ctrl.a_alu_input  = 1'b1;
                ctrl.b_alu_input  = B_SEL_REG;
                ctrl.alu_alt_ctrl = ALU_OP_SUB;
                ctrl.pc_branch    = PC_SRC_ALUOUT;
                ctrl.pc_we        = zero_i;
                ctrl.retire       = 1'b1;
            end
            S_ADDIWB: begin
                ctrl.enable_wrf = 1'b1;
                ctrl.retire     = 1'b1;
            end
            S_JUMP: begin
                ctrl.pc_branch = PC_SRC_JUMP;
                ctrl.pc_we     = 1'b1;
                ctrl.retire    = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/mcp_controller.sv
// Multicycle MIPS control unit: state register, opcode-driven next state and
// reset gating of every datapath control output.
//
// state      | meaning
// -----------+------------------------------------------------
// FETCH      | read instruction at PC, IR <= mem, PC <= PC+4
// DECODE     | ALUOut <= branch target, dispatch on opcode
// MEMADR     | ALUOut <= A + imm (LW/SW address)
// MEMREAD    | data register <= mem[ALUOut]
// MEMWB      | rt <= data register
// MEMWRITE   | mem[ALUOut] <= B
// EXECUTE    | ALUOut <= A op B (funct)
// ALUWB      | rd <= ALUOut
// BRANCH     | compare A, B; PC <= ALUOut when equal
// ADDIEX     | ALUOut <= A + imm
// ADDIWB     | rt <= ALUOut
// JUMP       | PC <= jump target
module mcp_controller
    import mcp_pkg::*;
(
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [31:0] instr_i32,
    input  logic        zero_i,
    output logic        pc_we_o,
    output logic [1:0]  pc_branch_o2,
    output logic        instr_or_data_o,
    output logic        instr_we_o,
    output logic        reg_dst_rtrd_o,
    output logic        mem_to_reg_o,
    output logic        enable_wrf_o,
    output logic        a_alu_input_o,
    output logic [1:0]  b_alu_input_o2,
    output logic [1:0]  alu_alt_ctrl_o2,
    output logic        mem_we_o,
    output logic        retire_o,
    output logic        illegal_o
);

    state_t     state_q;
    state_t     state_d;
    ctrl_t      ctrl;
    ctrl_t      ctrl_g;
    logic [5:0] opcode;
    logic       unused_instr_bits;

    assign opcode            = instr_i32[31:26];
    assign unused_instr_bits = ^instr_i32[25:0];

    always_ff @(posedge clk_i) begin
        if (reset_i) state_q <= S_FETCH;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                if (opcode == OP_LW)      state_d = S_MEMREAD;
                else if (opcode == OP_SW) state_d = S_MEMWRITE;
                else                      state_d = S_FETCH;
            end
            S_MEMREAD: state_d = S_MEMWB;
            S_EXECUTE: state_d = S_ALUWB;
            S_ADDIEX:  state_d = S_ADDIWB;
            default:   state_d = S_FETCH;
        endcase
    end

    mcp_ctrl_outputs u_outputs (
        .state  (state_q),
        .zero_i (zero_i),
        .ctrl   (ctrl)
    );

    // Reset overrides the decoded state so a half-finished instruction writes nothing.
    assign ctrl_g    = reset_i ? '0 : ctrl;
    assign illegal_o = !reset_i && (state_q == S_DECODE) && !is_supported(opcode);

    assign pc_we_o         = ctrl_g.pc_we;
    assign pc_branch_o2    = ctrl_g.pc_branch;
    assign instr_or_data_o = ctrl_g.instr_or_data;
    assign instr_we_o      = ctrl_g.instr_we;
    assign reg_dst_rtrd_o  = ctrl_g.reg_dst_rtrd;
    assign mem_to_reg_o    = ctrl_g.mem_to_reg;
    assign enable_wrf_o    = ctrl_g.enable_wrf;
    assign a_alu_input_o   = ctrl_g.a_alu_input;
    assign b_alu_input_o2  = ctrl_g.b_alu_input;
    assign alu_alt_ctrl_o2 = ctrl_g.alu_alt_ctrl;
    assign mem_we_o        = ctrl_g.mem_we;
    assign retire_o        = ctrl_g.retire;

endmodule

// File: tb/tb_mcp_controller.sv
// Directed-vector bench for mcp_controller: one row per clock cycle with the
// expected control word written out by hand for each state.
module tb_mcp_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr;
    logic        zero;
    logic        pc_we, instr_or_data, instr_we, reg_dst, mem_to_reg, enable_wrf;
    logic        a_sel, mem_we, retire, illegal;
    logic [1:0]  pc_branch, b_sel, alt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mcp_controller dut (
        .clk_i           (clk),
        .reset_i         (reset),
        .instr_i32       (instr),
        .zero_i          (zero),
        .pc_we_o         (pc_we),
        .pc_branch_o2    (pc_branch),
        .instr_or_data_o (instr_or_data),
        .instr_we_o      (instr_we),
        .reg_dst_rtrd_o  (reg_dst),
        .mem_to_reg_o    (mem_to_reg),
        .enable_wrf_o    (enable_wrf),
        .a_alu_input_o   (a_sel),
        .b_alu_input_o2  (b_sel),
        .alu_alt_ctrl_o2 (alt),
        .mem_we_o        (mem_we),
        .retire_o        (retire),
        .illegal_o       (illegal)
    );

    // Word layout: {pc_we, pc_branch[1:0], iord, ir_we, reg_dst, mem_to_reg,
    //               wrf, a, b[1:0], alt[1:0], mem_we, retire, illegal}
    localparam logic [16:0] E_ZERO    = {1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0};
    localparam logic [16:0] E_FETCH   = {1'b1, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 2'd0, 1'b0, 1'b0, 1'b0};
    localparam logic [16:0] E_DECODE  = {1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 2'd0, 1'b0, 1'b0, 1'b0};
    localparam logic [16:0] E_ILLDEC  = {1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 2'd0, 1'b0, 1'b0, 1'b1};
    localparam logic [16:0] E_MEMADR  = {1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 2'd0, 1'b0, 1'b0, 1'b0};
    localparam logic [16:0] E_MEMRD   = {1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0};
    localparam logic [16:0] E_MEMWB   = {1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0};
    localparam logic [16:0] E_MEMWR   = {1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1, 1'b1, 1'b0};
    localparam logic [16:0] E_EXEC    = {1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd2, 1'b0, 1'b0, 1'b0};
    localparam logic [16:0] E_ALUWB   = {1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0};
    localparam logic [16:0] E_BR_T    = {1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd1, 1'b0, 1'b1, 1'b0};
    localparam logic [16:0] E_BR_NT   = {1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd1, 1'b0, 1'b1, 1'b0};
    localparam logic [16:0] E_ADDIEX  = {1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 2'd0, 1'b0, 1'b0, 1'b0};
    localparam logic [16:0] E_ADDIWB  = {1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0};
    localparam logic [16:0] E_JUMP    = {1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0};

    localparam logic [31:0] I_LW    = 32'h8C080004;
    localparam logic [31:0] I_SW    = 32'hAC080004;
    localparam logic [31:0] I_RTYPE = 32'h01095020;
    localparam logic [31:0] I_BEQ   = 32'h11090003;
    localparam logic [31:0] I_J     = 32'h08000010;
    localparam logic [31:0] I_ADDI  = 32'h20080005;
    localparam logic [31:0] I_ILL   = 32'hFC000000;

    typedef struct {
        logic        rst;
        logic [31:0] ins;
        logic        z;
        logic [16:0] exp;
    } vec_t;

    vec_t vecs[64];
    int   nvec = 0;

    function automatic logic [16:0] actual();
        return {pc_we, pc_branch, instr_or_data, instr_we, reg_dst, mem_to_reg,
                enable_wrf, a_sel, b_sel, alt, mem_we, retire, illegal};
    endfunction

    task automatic add(input logic rst, input logic [31:0] ins, input logic z, input logic [16:0] exp);
        vecs[nvec].rst = rst;
        vecs[nvec].ins = ins;
        vecs[nvec].z   = z;
        vecs[nvec].exp = exp;
        nvec++;
    endtask

    task automatic check(input string name, input logic [16:0] exp);
        logic [16:0] act;
        act = actual();
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
        checks++;
        if (mem_we && enable_wrf) begin
            errors++;
            $display("FAIL %s exclusive: mem_we and enable_wrf both high", name);
        end
    endtask

    // Checks at the falling edge, then advances one rising edge.
    task automatic step(input string name, input logic [16:0] exp);
        @(negedge clk);
        check(name, exp);
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        instr = I_LW;
        zero  = 1'b0;

        add(1, I_LW, 0, E_ZERO);
        add(1, I_LW, 0, E_ZERO);
        add(0, I_LW, 0, E_FETCH);   add(0, I_LW, 0, E_DECODE);  add(0, I_LW, 0, E_MEMADR);
        add(0, I_LW, 0, E_MEMRD);   add(0, I_LW, 0, E_MEMWB);
        add(0, I_SW, 0, E_FETCH);   add(0, I_SW, 0, E_DECODE);  add(0, I_SW, 0, E_MEMADR);
        add(0, I_SW, 0, E_MEMWR);
        add(0, I_RTYPE, 1, E_FETCH); add(0, I_RTYPE, 1, E_DECODE); add(0, I_RTYPE, 1, E_EXEC);
        add(0, I_RTYPE, 1, E_ALUWB);
        add(0, I_BEQ, 1, E_FETCH);  add(0, I_BEQ, 1, E_DECODE); add(0, I_BEQ, 1, E_BR_T);
        add(0, I_BEQ, 0, E_FETCH);  add(0, I_BEQ, 0, E_DECODE); add(0, I_BEQ, 0, E_BR_NT);
        add(0, I_J, 0, E_FETCH);    add(0, I_J, 0, E_DECODE);   add(0, I_J, 0, E_JUMP);
        add(0, I_ADDI, 0, E_FETCH); add(0, I_ADDI, 0, E_DECODE); add(0, I_ADDI, 0, E_ADDIEX);
        add(0, I_ADDI, 0, E_ADDIWB);
        add(0, I_ILL, 0, E_FETCH);  add(0, I_ILL, 0, E_ILLDEC);
        add(0, I_RTYPE, 0, E_FETCH); add(0, I_RTYPE, 0, E_DECODE); add(0, I_RTYPE, 0, E_EXEC);
        add(1, I_RTYPE, 1, E_ZERO); add(1, I_RTYPE, 1, E_ZERO);
        add(0, I_RTYPE, 0, E_FETCH); add(0, I_RTYPE, 0, E_DECODE); add(0, I_RTYPE, 0, E_EXEC);
        add(0, I_RTYPE, 0, E_ALUWB);

        for (int i = 0; i < nvec; i++) begin
            reset = vecs[i].rst;
            instr = vecs[i].ins;
            zero  = vecs[i].z;
            step($sformatf("vec%0d", i), vecs[i].exp);
        end

        // BRANCH: pc_we follows zero_i combinationally within the cycle.
        reset = 1'b0;
        instr = I_BEQ;
        zero  = 1'b0;
        step("beq_fetch", E_FETCH);
        step("beq_decode", E_DECODE);
        @(negedge clk);
        check("beq_zero0", E_BR_NT);
        zero = 1'b1;
        #1;
        check("beq_zero1", E_BR_T);
        @(posedge clk);
        #1;
        zero = 1'b0;
        step("beq_after", E_FETCH);

        // Reset while a store is at MEMADR: no store strobe, then FETCH.
        instr = I_SW;
        step("sw_decode", E_DECODE);
        step("sw_memadr", E_MEMADR);
        reset = 1'b1;
        step("sw_reset", E_ZERO);
        reset = 1'b0;
        step("sw_refetch", E_FETCH);
        step("sw_redecode", E_DECODE);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
